// File: rtl/act_lut_rd_if.sv
// Lookup, result and config signals of the activation LUT reader.
interface act_lut_rd_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cfg_wr_en;
  logic [ADDR_WIDTH:0]   cfg_wr_addr;
  logic [DATA_WIDTH-1:0] cfg_wr_data;
  logic                  cfg_commit;
  logic                  cfg_err;
  logic                  in_vld;
  logic                  in_rdy;
  logic [ADDR_WIDTH-1:0] act_lut_addr;
  logic                  max_value_en;
  logic                  min_value_en;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] act_dat;
  logic                  bank_sel;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
    output in_vld, act_lut_addr, max_value_en, min_value_en, out_rdy,
    input  cfg_err, in_rdy, out_vld, act_dat, bank_sel
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
    input  in_vld, act_lut_addr, max_value_en, min_value_en, out_rdy,
    output cfg_err, in_rdy, out_vld, act_dat, bank_sel
  );
endinterface

// File: rtl/act_lut_rd.sv
// Activation LUT reader: double-buffered LUT plus saturation registers,
// read through a 2-stage stallable pipeline.
module act_lut_rd #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LUT_DEPTH  = 2 ** ADDR_WIDTH
) (
  input logic         i_clk,
  input logic         i_rst_n,
  act_lut_rd_if.slave bus
);
  localparam int unsigned         MaxIdx  = LUT_DEPTH;
  localparam int unsigned         MinIdx  = LUT_DEPTH + 1;
  localparam logic [ADDR_WIDTH:0] MaxAddr = MaxIdx[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] MinAddr = MinIdx[ADDR_WIDTH:0];
  localparam logic [DATA_WIDTH-1:0] MaxRst = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinRst = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] lut_q [2][LUT_DEPTH];
  logic [DATA_WIDTH-1:0] max_q [2];
  logic [DATA_WIDTH-1:0] min_q [2];
  logic                  bank_sel_q;
  logic                  cfg_err_q;
  logic                  shadow;
  logic                  wr_lut, wr_max, wr_min, wr_bad;

  logic                  advance;
  logic                  s1_vld_q, s1_max_q, s1_min_q, s1_tag_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] result;
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] act_dat_q;

  assign shadow = ~bank_sel_q;

  // Decode the config address into LUT / max / min / illegal targets.
  always_comb begin
    wr_lut = bus.cfg_wr_en && (bus.cfg_wr_addr < MaxAddr);
    wr_max = bus.cfg_wr_en && (bus.cfg_wr_addr == MaxAddr);
    wr_min = bus.cfg_wr_en && (bus.cfg_wr_addr == MinAddr);
    wr_bad = bus.cfg_wr_en && (bus.cfg_wr_addr > MinAddr);
  end

  // Config storage: writes always hit the shadow bank; commit swaps banks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(LUT_DEPTH); i++) lut_q[b][i] <= '0;
        max_q[b] <= MaxRst;
        min_q[b] <= MinRst;
      end
      bank_sel_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (wr_lut) lut_q[shadow][bus.cfg_wr_addr[ADDR_WIDTH-1:0]] <= bus.cfg_wr_data;
      if (wr_max) max_q[shadow] <= bus.cfg_wr_data;
      if (wr_min) min_q[shadow] <= bus.cfg_wr_data;
      if (wr_bad) cfg_err_q <= 1'b1;
      if (bus.cfg_commit) bank_sel_q <= ~bank_sel_q;
    end
  end

  // One advance enable for both stages; a stall freezes the whole pipe.
  assign advance    = ~out_vld_q | bus.out_rdy;
  assign bus.in_rdy = advance;

  // S1: capture the request and tag it with the bank active at acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_max_q  <= 1'b0;
      s1_min_q  <= 1'b0;
      s1_tag_q  <= 1'b0;
    end else if (advance) begin
      s1_vld_q  <= bus.in_vld;
      s1_addr_q <= bus.act_lut_addr;
      s1_max_q  <= bus.max_value_en;
      s1_min_q  <= bus.min_value_en;
      s1_tag_q  <= bank_sel_q;
    end
  end

  // Result select: max beats min beats LUT.
  always_comb begin
    result = lut_q[s1_tag_q][s1_addr_q];
    if (s1_max_q)      result = max_q[s1_tag_q];
    else if (s1_min_q) result = min_q[s1_tag_q];
  end

  // S2: output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q <= 1'b0;
      act_dat_q <= '0;
    end else if (advance) begin
      out_vld_q <= s1_vld_q;
      act_dat_q <= result;
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.act_dat  = act_dat_q;
  assign bus.bank_sel = bank_sel_q;
  assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_act_lut_rd.sv
// Directed bench for act_lut_rd with a scoreboard fed from a bank/LUT model.
module tb_act_lut_rd;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_lut_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  act_lut_rd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_lut [2][16];
  logic [DW-1:0] m_max [2];
  logic [DW-1:0] m_min [2];
  logic          m_bank;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] stall_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) m_lut[b][i] = '0;
      m_max[b] = 8'h7F;
      m_min[b] = 8'h80;
    end
    m_bank = 1'b0;
  endtask

  // One clock: predict on acceptance, update the model, clear one-shot strobes.
  task automatic tick();
    logic acc;
    logic [DW-1:0] e;
    @(negedge clk);
    acc = bus.in_vld && bus.in_rdy;
    if (acc) begin
      if (bus.max_value_en)      e = m_max[m_bank];
      else if (bus.min_value_en) e = m_min[m_bank];
      else                       e = m_lut[m_bank][bus.act_lut_addr];
      exp_q.push_back(e);
    end
    if (bus.cfg_wr_en) begin
      if (bus.cfg_wr_addr < 5'd16)       m_lut[~m_bank][bus.cfg_wr_addr[3:0]] = bus.cfg_wr_data;
      else if (bus.cfg_wr_addr == 5'd16) m_max[~m_bank] = bus.cfg_wr_data;
      else if (bus.cfg_wr_addr == 5'd17) m_min[~m_bank] = bus.cfg_wr_data;
    end
    if (bus.cfg_commit) m_bank = ~m_bank;
    @(posedge clk);
    #1;
    bus.cfg_wr_en  = 1'b0;
    bus.cfg_commit = 1'b0;
    if (acc) bus.in_vld = 1'b0;
  endtask

  task automatic cfg_write(input logic [AW:0] a, input logic [DW-1:0] d);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = a;
    bus.cfg_wr_data = d;
    tick();
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic mx, input logic mn);
    bus.in_vld       = 1'b1;
    bus.act_lut_addr = a;
    bus.max_value_en = mx;
    bus.min_value_en = mn;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic mx, input logic mn);
    drive(a, mx, mn);
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every transferred result must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", bus.out_vld, 1'b0);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", bus.act_dat, exp_v);
      end
    end
  end

  initial begin
    bus.cfg_wr_en    = 1'b0;
    bus.cfg_wr_addr  = '0;
    bus.cfg_wr_data  = '0;
    bus.cfg_commit   = 1'b0;
    bus.in_vld       = 1'b0;
    bus.act_lut_addr = '0;
    bus.max_value_en = 1'b0;
    bus.min_value_en = 1'b0;
    bus.out_rdy      = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", bus.out_vld, 1'b0);
    check("rst_act_dat", bus.act_dat, 8'h00);
    check("rst_cfg_err", bus.cfg_err, 1'b0);
    check("rst_bank_sel", bus.bank_sel, 1'b0);
    check("rst_in_rdy", bus.in_rdy, 1'b1);
    rst_n = 1'b1;
    tick();

    // 1: program LUT[k] = 3k-20 into the shadow, commit, stream all addresses.
    for (int k = 0; k < 16; k++) cfg_write(5'(k), 8'(k * 3 - 20));
    commit();
    check("t1_bank_sel", bus.bank_sel, 1'b1);
    send(4'd0, 1'b0, 1'b0);
    check("t1_lat_1", bus.out_vld, 1'b0);
    send(4'd1, 1'b0, 1'b0);
    check("t1_lat_2", bus.out_vld, 1'b1);
    check("t1_first", bus.act_dat, 8'hEC);
    for (int k = 2; k < 16; k++) send(4'(k), 1'b0, 1'b0);
    drain("t1_drain");

    // 2: saturation registers; min write shares the commit cycle.
    cfg_write(5'd16, 8'h40);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = 5'd17;
    bus.cfg_wr_data = 8'hC0;
    commit();
    check("t2_bank_sel", bus.bank_sel, 1'b0);
    send(4'd3, 1'b1, 1'b0);
    send(4'd3, 1'b0, 1'b1);
    send(4'd3, 1'b1, 1'b1);
    drain("t2_drain");

    // 3: bank0[5]=22 active, bank1[5]=11 shadow; lookups straddle the commit.
    commit();
    cfg_write(5'd5, 8'h22);
    commit();
    cfg_write(5'd5, 8'h11);
    drive(4'd5, 1'b0, 1'b0);
    bus.cfg_commit = 1'b1;
    tick();
    send(4'd5, 1'b0, 1'b0);
    drain("t3_drain");
    check("t3_bank_sel", bus.bank_sel, 1'b1);

    // 4: stall with three items queued.
    bus.out_rdy = 1'b0;
    send(4'd0, 1'b0, 1'b0);
    send(4'd1, 1'b0, 1'b0);
    drive(4'd2, 1'b0, 1'b0);
    stall_dat = bus.act_dat;
    check("t4_stall_head", stall_dat, exp_q[0]);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_in_rdy", bus.in_rdy, 1'b0);
      check("t4_out_vld", bus.out_vld, 1'b1);
      check("t4_act_dat", bus.act_dat, stall_dat);
    end
    check("t4_queued", exp_q.size(), 2);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 10 && bus.in_vld; i++) tick();
    check("t4_third_taken", bus.in_vld, 1'b0);
    drain("t4_drain");

    // 5: illegal config address is sticky and writes nothing.
    cfg_write(5'd20, 8'h5A);
    check("t5_err", bus.cfg_err, 1'b1);
    repeat (3) tick();
    commit();
    check("t5_err_sticky", bus.cfg_err, 1'b1);
    send(4'd4, 1'b0, 1'b0);
    send(4'd4, 1'b1, 1'b0);
    send(4'd4, 1'b0, 1'b1);
    drain("t5_drain");

    // 6: reset with two items in flight.
    commit();
    send(4'd5, 1'b0, 1'b0);
    send(4'd6, 1'b0, 1'b0);
    check("t6_inflight", bus.out_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check("t6_rst_out_vld", bus.out_vld, 1'b0);
    check("t6_rst_bank_sel", bus.bank_sel, 1'b0);
    check("t6_rst_cfg_err", bus.cfg_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_no_out", bus.out_vld, 1'b0);
    send(4'd5, 1'b0, 1'b0);
    send(4'd0, 1'b1, 1'b0);
    send(4'd0, 1'b0, 1'b1);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
